// File: rtl/vp_mem_pkg.sv
// Shared types for the memory-access stage: mem_in field layout,
// branch condition codes and the stage FSM states.
package vp_mem_pkg;
  localparam int MEM_RD  = 0;
  localparam int MEM_WR  = 1;
  localparam int MEM_BR  = 2;
  localparam int COND_LO = 3;
  localparam int COND_HI = 4;

  typedef enum logic [1:0] {
    C_AL = 2'b00,
    C_EQ = 2'b01,
    C_NE = 2'b10,
    C_LT = 2'b11
  } cond_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mstate_e;
endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: NZCV flags x condition code -> taken.
module cond_eval
  import vp_mem_pkg::*;
(
  input  logic [3:0] i_nzcv,
  input  cond_e      i_cond,
  output logic       o_taken
);
  logic w_n, w_z, w_v;
  assign w_n = i_nzcv[3];
  assign w_z = i_nzcv[2];
  assign w_v = i_nzcv[0];

  // Decode the condition against the flags
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      C_AL:    o_taken = 1'b1;
      C_EQ:    o_taken = w_z;
      C_NE:    o_taken = ~w_z;
      C_LT:    o_taken = w_n ^ w_v;
      default: o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per instruction over a
// req/ack handshake, upstream stall while in flight, branch resolution.
// Optional macro MEM_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYCLES
// cycles without ack and report it through fault.
module mem_stage
  import vp_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [4:0]        mem_in,
  input  logic [1:0]        wb_in,
  input  logic [31:0]       r2_in,
  input  logic [31:0]       resALU_in,
  input  logic [3:0]        NZCV_in,
  input  logic [26:0]       branchDir_in,
  input  logic [3:0]        dest_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              valid_out,
  output logic [1:0]        wb_out,
  output logic [31:0]       readData_out,
  output logic [31:0]       resALU_out,
  output logic [3:0]        dest_out,
  output logic              branch_taken,
  output logic [26:0]       branch_target,
  output logic              fault
);
  mstate_e     r_state;
  logic [1:0]  r_wb;
  logic [3:0]  r_dest;
  logic [31:0] r_resalu;
  logic        r_taken;
  logic [26:0] r_target;

  logic w_memop, w_cond_taken, w_taken, w_timeout;

  assign w_memop = valid_in & (mem_in[MEM_RD] | mem_in[MEM_WR]);
  assign w_taken = mem_in[MEM_BR] & w_cond_taken;

  cond_eval u_cond (
    .i_nzcv  (NZCV_in),
    .i_cond  (cond_e'(mem_in[COND_HI:COND_LO])),
    .o_taken (w_cond_taken)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;

  assign w_timeout = (r_state == WAIT) & ~dmem_ack &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fault     = r_fault;

  // Count unacknowledged WAIT cycles; fault pulses alongside the abort valid_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_timeout;
      if ((r_state == WAIT) && !dmem_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                              r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

  // Hold upstream on accept and for every WAIT cycle that does not retire the op
  assign stall = ((r_state == IDLE) & w_memop) |
                 ((r_state == WAIT) & ~dmem_ack & ~w_timeout);

  // Stage FSM, memory handshake and MEM/WB output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wb          <= '0;
      r_dest        <= '0;
      r_resalu      <= '0;
      r_taken       <= 1'b0;
      r_target      <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      valid_out     <= 1'b0;
      wb_out        <= '0;
      readData_out  <= '0;
      resALU_out    <= '0;
      dest_out      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      valid_out    <= 1'b0;
      branch_taken <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_memop) begin
            // Both read and write set resolves to a store
            r_state    <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_in[MEM_WR];
            dmem_addr  <= resALU_in[ADDR_W+1:2];
            dmem_wdata <= r2_in;
            r_wb       <= wb_in;
            r_dest     <= dest_in;
            r_resalu   <= resALU_in;
            r_taken    <= w_taken;
            r_target   <= branchDir_in;
          end else if (valid_in) begin
            valid_out     <= 1'b1;
            wb_out        <= wb_in;
            readData_out  <= '0;
            resALU_out    <= resALU_in;
            dest_out      <= dest_in;
            branch_taken  <= w_taken;
            branch_target <= branchDir_in;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            r_state       <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            valid_out     <= 1'b1;
            wb_out        <= r_wb;
            readData_out  <= dmem_we ? 32'h0 : dmem_rdata;
            resALU_out    <= r_resalu;
            dest_out      <= r_dest;
            branch_taken  <= r_taken;
            branch_target <= r_target;
          end else if (w_timeout) begin
            // Aborted access: suppress write-back and any redirect
            r_state       <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            valid_out     <= 1'b1;
            wb_out        <= '0;
            readData_out  <= '0;
            resALU_out    <= r_resalu;
            dest_out      <= r_dest;
            branch_target <= r_target;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (inputs driven and outputs
// sampled on the falling edge).
module tb_mem_stage;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [4:0]        mem_in;
  logic [1:0]        wb_in;
  logic [31:0]       r2_in, resALU_in;
  logic [3:0]        NZCV_in;
  logic [26:0]       branchDir_in;
  logic [3:0]        dest_in;
  logic              stall, dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              valid_out;
  logic [1:0]        wb_out;
  logic [31:0]       readData_out, resALU_out;
  logic [3:0]        dest_out;
  logic              branch_taken;
  logic [26:0]       branch_target;
  logic              fault;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_in(mem_in), .wb_in(wb_in),
    .r2_in(r2_in), .resALU_in(resALU_in), .NZCV_in(NZCV_in),
    .branchDir_in(branchDir_in), .dest_in(dest_in), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .wb_out(wb_out), .readData_out(readData_out),
    .resALU_out(resALU_out), .dest_out(dest_out), .branch_taken(branch_taken),
    .branch_target(branch_target), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] m, input logic [31:0] alu,
                       input logic [31:0] r2, input logic [3:0] d, input logic [1:0] wb);
    valid_in = v; mem_in = m; resALU_in = alu; r2_in = r2; dest_in = d; wb_in = wb;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int cnt;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; NZCV_in = '0; branchDir_in = '0;
    drive(1'b0, 5'b0, 32'h0, 32'h0, 4'h0, 2'b00);
    cyc(); cyc();
    chk("rst_req",   dmem_req, 0);
    chk("rst_we",    dmem_we, 0);
    chk("rst_vout",  valid_out, 0);
    chk("rst_taken", branch_taken, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rdata", readData_out, 0);
    chk("rst_alu",   resALU_out, 0);
    rst = 1'b0;

    // 1: plain ALU op
    drive(1'b1, 5'b00000, 32'h1234, 32'h0, 4'd3, 2'b10);
    #1 chk("alu_stall_acc", stall, 0);
    cyc();
    chk("alu_vout",  valid_out, 1);
    chk("alu_res",   resALU_out, 32'h1234);
    chk("alu_dest",  dest_out, 3);
    chk("alu_wb",    wb_out, 2'b10);
    chk("alu_stall", stall, 0);
    chk("alu_req",   dmem_req, 0);
    valid_in = 1'b0;
    cyc();
    chk("alu_vout_pulse", valid_out, 0);

    // 2: load, ack in third request cycle
    drive(1'b1, 5'b00001, 32'h40, 32'h0, 4'd5, 2'b01);
    #1 chk("ld_stall_c0", stall, 1);
    cyc();
    chk("ld_req_c1",   dmem_req, 1);
    chk("ld_we",       dmem_we, 0);
    chk("ld_addr",     dmem_addr, 10'h10);
    chk("ld_stall_c1", stall, 1);
    chk("ld_vout_c1",  valid_out, 0);
    cyc();
    chk("ld_req_c2",   dmem_req, 1);
    chk("ld_stall_c2", stall, 1);
    cyc();
    chk("ld_req_c3",   dmem_req, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", stall, 0);
    valid_in = 1'b0;
    cyc();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("ld_vout",  valid_out, 1);
    chk("ld_rdata", readData_out, 32'hDEADBEEF);
    chk("ld_req_dn", dmem_req, 0);
    chk("ld_wb",    wb_out, 2'b01);
    chk("ld_dest",  dest_out, 5);
    chk("ld_res",   resALU_out, 32'h40);
    chk("ld_fault", fault, 0);
    cyc();
    chk("ld_vout_pulse", valid_out, 0);

    // 3: store, ack in first request cycle
    drive(1'b1, 5'b00010, 32'h8, 32'hCAFEF00D, 4'd7, 2'b11);
    cyc();
    chk("st_req",   dmem_req, 1);
    chk("st_we",    dmem_we, 1);
    chk("st_addr",  dmem_addr, 10'h2);
    chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
    dmem_ack = 1'b1; valid_in = 1'b0;
    cyc();
    dmem_ack = 1'b0;
    chk("st_rdata0", readData_out, 0);
    cnt = int'(valid_out);
    for (int i = 0; i < 4; i++) begin
      cyc();
      cnt += int'(valid_out);
    end
    chk("st_one_vout", cnt, 1);

    // Both read and write set: store
    drive(1'b1, 5'b00011, 32'hC, 32'h55, 4'd1, 2'b01);
    cyc();
    chk("rw_we", dmem_we, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111; valid_in = 1'b0;
    cyc();
    dmem_ack = 1'b0;
    chk("rw_rdata0", readData_out, 0);

    // 4: branch conditions
    branchDir_in = 27'h155;
    drive(1'b1, 5'b10100, 32'h0, 32'h0, 4'd0, 2'b00);
    NZCV_in = 4'b0100;
    cyc();
    chk("ne_z1_vout",  valid_out, 1);
    chk("ne_z1_taken", branch_taken, 0);
    NZCV_in = 4'b0000;
    cyc();
    chk("ne_z0_taken",  branch_taken, 1);
    chk("ne_z0_target", branch_target, 27'h155);
    mem_in = 5'b01100; NZCV_in = 4'b0000;
    cyc();
    chk("eq_z0_taken", branch_taken, 0);
    mem_in = 5'b11100; NZCV_in = 4'b1000;
    cyc();
    chk("lt_nv_taken", branch_taken, 1);
    mem_in = 5'b11100; NZCV_in = 4'b1001;
    cyc();
    chk("lt_eq_taken", branch_taken, 0);
    mem_in = 5'b00000; NZCV_in = 4'b0000;
    cyc();
    chk("nobr_taken", branch_taken, 0);
    valid_in = 1'b0;
    cyc();
    chk("br_idle_taken", branch_taken, 0);

    // Load + AL branch: taken presented with the load result
    branchDir_in = 27'h2AB;
    drive(1'b1, 5'b00101, 32'h20, 32'h0, 4'd2, 2'b10);
    cyc();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D; valid_in = 1'b0;
    cyc();
    dmem_ack = 1'b0;
    chk("ldbr_rdata",  readData_out, 32'h0BADF00D);
    chk("ldbr_taken",  branch_taken, 1);
    chk("ldbr_target", branch_target, 27'h2AB);

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("idle_ack_vout", valid_out, 0);
    chk("idle_ack_req",  dmem_req, 0);

    // 5: reset during WAIT, late ack
    drive(1'b1, 5'b00001, 32'h40, 32'h0, 4'd9, 2'b01);
    cyc();
    chk("rw5_req_w1", dmem_req, 1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rw5_req_rst", dmem_req, 0);
    rst = 1'b0; valid_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h77;
    cnt = int'(valid_out);
    cyc();
    dmem_ack = 1'b0;
    cnt += int'(valid_out);
    chk("rw5_no_vout", cnt, 0);
    chk("rw5_req",     dmem_req, 0);
    chk("rw5_idle",    stall, 0);
    drive(1'b1, 5'b00000, 32'h99, 32'h0, 4'd4, 2'b00);
    cyc();
    chk("rw5_alu_after", valid_out, 1);
    valid_in = 1'b0;
    cyc();

`ifdef MEM_TIMEOUT_EN
    // 6: no ack ever -> timeout fault after 8 WAIT cycles
    begin
      int reqs;
      bit seen;
      reqs = 0; seen = 1'b0;
      drive(1'b1, 5'b00001, 32'h40, 32'h0, 4'd6, 2'b11);
      for (int i = 0; i < 40 && !seen; i++) begin
        cyc();
        if (valid_out) seen = 1'b1;
        else if (dmem_req) begin
          reqs++;
          valid_in = 1'b0;
        end
      end
      chk("to_seen",  seen, 1);
      chk("to_reqs",  reqs, 8);
      chk("to_fault", fault, 1);
      chk("to_wb",    wb_out, 0);
      chk("to_rdata", readData_out, 0);
      chk("to_req",   dmem_req, 0);
      cyc();
      chk("to_fault_pulse", fault, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
